// File: rtl/mnist_pixel_compositor_if.sv
// Pixel bus between the VGA sync generator and the compositor:
// beam position and frame pulse in, composed RGB out.
interface mnist_pixel_compositor_if;
    logic       pix_valid;
    logic       frame_start;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       rgb_valid;
    logic [7:0] Red;
    logic [7:0] Green;
    logic [7:0] Blue;

    modport master (
        output pix_valid, frame_start, DrawX, DrawY,
        input  rgb_valid, Red, Green, Blue
    );

    modport slave (
        input  pix_valid, frame_start, DrawX, DrawY,
        output rgb_valid, Red, Green, Blue
    );
endinterface

// File: rtl/mnist_pixel_compositor.sv
// Three-stage pixel compositor: cursor, score panel, canvas and frame ring.
// Define ARGMAX_HIGHLIGHT_EN to build the per-frame argmax engine and row highlight.
module mnist_pixel_compositor #(
    parameter int unsigned CANVAS_N   = 28,
    parameter int unsigned CELL       = 14,
    parameter int unsigned CANVAS_X0  = 199,
    parameter int unsigned CANVAS_Y0  = 43,
    parameter int unsigned PIX_W      = 16,
    parameter int unsigned SHADE_LSB  = 3,
    parameter int unsigned NN_CLASSES = 10,
    parameter int unsigned PANEL_X0   = 55,
    parameter int unsigned PANEL_Y0   = 164,
    parameter int unsigned ROW_H      = 15,
    parameter int unsigned GLYPH_W    = 11
) (
    input  logic                                   Clk,
    input  logic                                   Reset,
    mnist_pixel_compositor_if.slave                pix,
    input  logic [9:0]                             BallX,
    input  logic [9:0]                             BallY,
    input  logic [9:0]                             Ball_size,
    input  logic [8*NN_CLASSES-1:0]                scores,
    output logic [$clog2(CANVAS_N*CANVAS_N)-1:0]   canvas_addr,
    input  logic [PIX_W-1:0]                       canvas_q,
    output logic [7:0]                             glyph_addr,
    input  logic [GLYPH_W-1:0]                     glyph_row,
    output logic [3:0]                             pred_class,
    output logic                                   pred_valid
);
    localparam int unsigned AW         = $clog2(CANVAS_N * CANVAS_N);
    localparam int unsigned GW         = $clog2(GLYPH_W);
    localparam int unsigned CanvasSpan = CANVAS_N * CELL;
    localparam int unsigned RingSpan   = CanvasSpan + 4;
    localparam int unsigned PanelH     = NN_CLASSES * ROW_H;
    localparam int unsigned BarX0      = 2 * GLYPH_W;
    localparam int unsigned HlW        = 4 * GLYPH_W;

    // S0: input registers; coordinates only move on a valid pixel so addresses stay put
    logic       v0;
    logic [9:0] x0, y0, bx0, by0, br0;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            v0  <= 1'b0;
            x0  <= '0;
            y0  <= '0;
            bx0 <= '0;
            by0 <= '0;
            br0 <= '0;
        end else begin
            v0 <= pix.pix_valid;
            if (pix.pix_valid) begin
                x0  <= pix.DrawX;
                y0  <= pix.DrawY;
                bx0 <= BallX;
                by0 <= BallY;
                br0 <= Ball_size;
            end
        end
    end

    logic [7:0] shadow_q [NN_CLASSES];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < int'(NN_CLASSES); i++) shadow_q[i] <= '0;
        end else if (pix.frame_start) begin
            for (int i = 0; i < int'(NN_CLASSES); i++) shadow_q[i] <= scores[8*i +: 8];
        end
    end

    // Offsets wrap to large values when left/above an origin, so one unsigned compare bounds both sides
    logic [11:0] cdx, cdy, pdx, pdy, cell_x, cell_y;
    logic        canvas_in, border_in, panel_y_in, glyph_in, bar_in, hl_in, cursor_in;
    logic [3:0]  prow;
    logic [7:0]  row_score;
    logic signed [11:0] bdx, bdy;
    logic signed [23:0] sqx, sqy;
    logic [23:0] dist2, rad2;

    assign cdx        = {2'b00, x0} - 12'(CANVAS_X0);
    assign cdy        = {2'b00, y0} - 12'(CANVAS_Y0);
    assign cell_x     = cdx / 12'(CELL);
    assign cell_y     = cdy / 12'(CELL);
    assign canvas_in  = (cdx < 12'(CanvasSpan)) && (cdy < 12'(CanvasSpan));
    assign border_in  = !canvas_in && (cdx + 12'd2 < 12'(RingSpan)) && (cdy + 12'd2 < 12'(RingSpan));
    assign canvas_addr = canvas_in ? AW'(cell_y * 12'(CANVAS_N) + cell_x) : '0;

    assign pdx        = {2'b00, x0} - 12'(PANEL_X0);
    assign pdy        = {2'b00, y0} - 12'(PANEL_Y0);
    assign panel_y_in = pdy < 12'(PanelH);
    assign prow       = 4'(pdy / 12'(ROW_H));
    // row*ROW_H + line is just the offset into the panel
    assign glyph_addr = panel_y_in ? 8'(pdy) : 8'd0;
    assign row_score  = shadow_q[panel_y_in ? prow : 4'd0];
    assign glyph_in   = panel_y_in && (pdx < 12'(GLYPH_W));
    assign bar_in     = panel_y_in && (pdx >= 12'(BarX0))
                        && (pdx < 12'(BarX0) + {6'd0, row_score[7:2]});

    assign bdx       = $signed({2'b00, x0}) - $signed({2'b00, bx0});
    assign bdy       = $signed({2'b00, y0}) - $signed({2'b00, by0});
    assign sqx       = bdx * bdx;
    assign sqy       = bdy * bdy;
    assign dist2     = $unsigned(sqx) + $unsigned(sqy);
    assign rad2      = {14'd0, br0} * {14'd0, br0};
    assign cursor_in = dist2 <= rad2;

`ifdef ARGMAX_HIGHLIGHT_EN
    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;
    state_e     state_q;
    logic [3:0] idx_q, best_idx_q;
    logic [7:0] best_val_q;

    // pred_class only moves on entering StDone, so the highlight is stable during a scan
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
            pred_class <= '0;
            pred_valid <= 1'b0;
        end else if (pix.frame_start) begin
            state_q    <= StScan;
            idx_q      <= 4'd1;
            best_idx_q <= '0;
            best_val_q <= scores[7:0];
            pred_valid <= 1'b0;
        end else if (state_q == StScan) begin
            if (shadow_q[idx_q] > best_val_q) begin
                best_val_q <= shadow_q[idx_q];
                best_idx_q <= idx_q;
            end
            idx_q <= idx_q + 4'd1;
            if (idx_q == 4'(NN_CLASSES - 1)) begin
                state_q    <= StDone;
                pred_class <= (shadow_q[idx_q] > best_val_q) ? idx_q : best_idx_q;
                pred_valid <= 1'b1;
            end
        end
    end

    assign hl_in = panel_y_in && (prow == pred_class) && (pdx < 12'(HlW));
`else
    assign pred_class = 4'hF;
    assign pred_valid = 1'b0;
    assign hl_in      = 1'b0;
`endif

    // S1: memories respond; geometry flags travel alongside
    logic          v1, cursor1, glyph1, bar1, hl1, canvas1, border1;
    logic [GW-1:0] gcol1;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            v1      <= 1'b0;
            cursor1 <= 1'b0;
            glyph1  <= 1'b0;
            bar1    <= 1'b0;
            hl1     <= 1'b0;
            canvas1 <= 1'b0;
            border1 <= 1'b0;
            gcol1   <= '0;
        end else begin
            v1      <= v0;
            cursor1 <= cursor_in;
            glyph1  <= glyph_in;
            bar1    <= bar_in;
            hl1     <= hl_in;
            canvas1 <= canvas_in;
            border1 <= border_in;
            gcol1   <= pdx[GW-1:0];
        end
    end

    // S2: priority compose
    logic [7:0]  gray;
    logic [23:0] rgb_d;

    assign gray = canvas_q[SHADE_LSB +: 8];

    always_comb begin
        rgb_d = 24'h000000;
        if (cursor1)                        rgb_d = 24'hFF0000;
        else if (glyph1 && glyph_row[gcol1]) rgb_d = 24'h888888;
        else if (bar1)                      rgb_d = 24'h00C000;
        else if (hl1)                       rgb_d = 24'h202060;
        else if (canvas1)                   rgb_d = {gray, gray, gray};
        else if (border1)                   rgb_d = 24'h888888;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pix.rgb_valid <= 1'b0;
            pix.Red       <= '0;
            pix.Green     <= '0;
            pix.Blue      <= '0;
        end else begin
            pix.rgb_valid <= v1;
            {pix.Red, pix.Green, pix.Blue} <= v1 ? rgb_d : 24'h000000;
        end
    end

    logic unused_canvas;
    assign unused_canvas = ^canvas_q;
endmodule
